// File: rtl/victim_buffer.sv
`default_nettype none
// ============================================================================
// victim_buffer : write-back victim FIFO between the I-cache evict port and
//                 the memory port, with watermark draining and lookup.
// Optional feature macro: VICTIM_BUFFER_COALESCE_EN (in-place overwrite of
//                 a pushed block whose index is already buffered).
// Revision: 1.0
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef IDX_LEN
`define IDX_LEN(n) $clog2(n)
`endif

`ifndef VICTIM_BUFFER_MEM_TYPES
`define VICTIM_BUFFER_MEM_TYPES
typedef logic [63:0] mem_blk_t;
typedef logic [3:0]  mem_tag_t;
typedef enum logic [1:0] {
  MEM_CMD_NONE  = 2'd0,
  MEM_CMD_LOAD  = 2'd1,
  MEM_CMD_STORE = 2'd2
} mem_cmd_t;
`endif

module victim_buffer #(
  parameter int DEPTH      = 4,
  parameter int HIGH_WATER = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             evict_valid,
  input  logic [`XLEN-4:0] evict_idx,
  input  mem_blk_t         evict_blk,
  output logic             evict_ready,
  input  logic [`XLEN-4:0] lookup_idx,
  output logic             lookup_hit,
  output mem_blk_t         lookup_blk,
  input  logic             flush,
  output logic             empty,
  output mem_cmd_t         mem_qry_cmd,
  output logic [`XLEN-4:0] mem_qry_idx,
  output mem_blk_t         mem_qry_blk,
  input  mem_tag_t         mem_ack
);

  localparam int c_ptr_w = `IDX_LEN(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_high  = c_cnt_w'(HIGH_WATER);
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_drain = 1'b1;

  logic [DEPTH-1:0]   r_valid;
  logic [`XLEN-4:0]   r_idx [DEPTH];
  mem_blk_t           r_blk [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic [0:0]         r_state;

  logic               w_storing;
  logic               w_pop;
  logic               w_push;
  logic               w_coal;
  logic               w_alloc;
  logic [c_ptr_w-1:0] w_coal_slot;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [0:0]         w_state_nxt;

  assign evict_ready = (r_count < c_depth);
  assign empty       = (r_count == '0);

  // Memory request comes purely from registered state; ack only decides the pop.
  assign w_storing   = (r_state == c_st_drain) && (r_count != '0);
  assign w_pop       = w_storing && (mem_ack != '0);
  assign w_push      = evict_valid && evict_ready;
  assign mem_qry_cmd = w_storing ? MEM_CMD_STORE : MEM_CMD_NONE;
  assign mem_qry_idx = w_storing ? r_idx[r_head] : '0;
  assign mem_qry_blk = w_storing ? r_blk[r_head] : '0;

  // Walk from oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    logic [c_ptr_w-1:0] w_slot;
    lookup_hit = 1'b0;
    lookup_blk = '0;
    w_slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_head + c_ptr_w'(k);
      if (r_valid[w_slot] && (r_idx[w_slot] == lookup_idx)) begin
        lookup_hit = 1'b1;
        lookup_blk = r_blk[w_slot];
      end
    end
  end

`ifdef VICTIM_BUFFER_COALESCE_EN
  // A head that leaves this cycle cannot absorb the push; it gets a fresh entry.
  always_comb begin
    logic [c_ptr_w-1:0] w_slot;
    w_coal      = 1'b0;
    w_coal_slot = '0;
    w_slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_head + c_ptr_w'(k);
      if (r_valid[w_slot] && (r_idx[w_slot] == evict_idx) &&
          !(w_pop && (w_slot == r_head))) begin
        w_coal      = w_push;
        w_coal_slot = w_slot;
      end
    end
  end
`else
  assign w_coal      = 1'b0;
  assign w_coal_slot = '0;
`endif

  assign w_alloc = w_push && !w_coal;

  always_comb begin
    w_count_nxt = r_count;
    if (w_alloc && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_alloc && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  // Decisions use the next count so a push with flush high stores next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if ((w_count_nxt >= c_high) || flush) begin
          w_state_nxt = c_st_drain;
        end
      end
      default: begin
        if ((r_count == '0) || (w_count_nxt == '0) ||
            ((w_count_nxt < c_high) && !flush)) begin
          w_state_nxt = c_st_idle;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i] <= '0;
        r_blk[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_w'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_idx[r_tail]   <= evict_idx;
        r_blk[r_tail]   <= evict_blk;
        r_tail          <= r_tail + c_ptr_w'(1);
      end
      if (w_coal) begin
        r_blk[w_coal_slot] <= evict_blk;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_victim_buffer.sv
`default_nettype none
// ============================================================================
// tb_victim_buffer : directed vector table plus short hand-written sequences.
// Revision: 1.0
// ============================================================================
module tb_victim_buffer;

  localparam int IW = 29;
  localparam int BW = 64;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic          clock = 1'b0;
  logic          reset;
  logic          evict_valid;
  logic [IW-1:0] evict_idx;
  logic [BW-1:0] evict_blk;
  logic          evict_ready;
  logic [IW-1:0] lookup_idx;
  logic          lookup_hit;
  logic [BW-1:0] lookup_blk;
  logic          flush;
  logic          empty;
  logic [1:0]    mem_qry_cmd;
  logic [IW-1:0] mem_qry_idx;
  logic [BW-1:0] mem_qry_blk;
  logic [3:0]    mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  victim_buffer #(.DEPTH(4), .HIGH_WATER(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .evict_valid (evict_valid),
    .evict_idx   (evict_idx),
    .evict_blk   (evict_blk),
    .evict_ready (evict_ready),
    .lookup_idx  (lookup_idx),
    .lookup_hit  (lookup_hit),
    .lookup_blk  (lookup_blk),
    .flush       (flush),
    .empty       (empty),
    .mem_qry_cmd (mem_qry_cmd),
    .mem_qry_idx (mem_qry_idx),
    .mem_qry_blk (mem_qry_blk),
    .mem_ack     (mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          ev;
    logic [IW-1:0] eidx;
    logic [BW-1:0] eblk;
    logic [IW-1:0] lidx;
    logic          fl;
    logic [3:0]    ack;
    logic          x_rdy;
    logic          x_emp;
    logic          x_hit;
    logic [BW-1:0] x_lblk;
    logic [1:0]    x_cmd;
    logic [IW-1:0] x_qidx;
    logic [BW-1:0] x_qblk;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic ev, input logic [IW-1:0] eidx,
                              input logic [BW-1:0] eblk, input logic [IW-1:0] lidx,
                              input logic fl, input logic [3:0] ack,
                              input logic rdy, input logic emp, input logic hit,
                              input logic [BW-1:0] lblk, input logic [1:0] cmd,
                              input logic [IW-1:0] qidx, input logic [BW-1:0] qblk);
    vec_t v;
    v.ev = ev; v.eidx = eidx; v.eblk = eblk; v.lidx = lidx; v.fl = fl; v.ack = ack;
    v.x_rdy = rdy; v.x_emp = emp; v.x_hit = hit; v.x_lblk = lblk;
    v.x_cmd = cmd; v.x_qidx = qidx; v.x_qblk = qblk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic emp, input logic hit,
                         input logic [BW-1:0] lblk, input logic [1:0] cmd,
                         input logic [IW-1:0] qidx, input logic [BW-1:0] qblk);
    chk($sformatf("%s ready", tag), 64'(evict_ready), 64'(rdy));
    chk($sformatf("%s empty", tag), 64'(empty), 64'(emp));
    chk($sformatf("%s hit", tag), 64'(lookup_hit), 64'(hit));
    chk($sformatf("%s lblk", tag), lookup_blk, lblk);
    chk($sformatf("%s cmd", tag), 64'(mem_qry_cmd), 64'(cmd));
    chk($sformatf("%s qidx", tag), 64'(mem_qry_idx), 64'(qidx));
    chk($sformatf("%s qblk", tag), mem_qry_blk, qblk);
  endtask

  task automatic drive(input logic ev, input logic [IW-1:0] ei, input logic [BW-1:0] eb,
                       input logic [IW-1:0] li, input logic fl, input logic [3:0] ak);
    evict_valid = ev;
    evict_idx   = ei;
    evict_blk   = eb;
    lookup_idx  = li;
    flush       = fl;
    mem_ack     = ak;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ev eidx eblk lidx fl ack | rdy emp hit lblk cmd qidx qblk
    vecs[0]  = mk(0, 0,     0,       'h10, 0, 0, 1, 1, 0, 0,       CMD_NONE,  0,     0);
    vecs[1]  = mk(1, 'h10,  'h1111,  'h10, 0, 0, 1, 1, 0, 0,       CMD_NONE,  0,     0);
    vecs[2]  = mk(1, 'h11,  'h2222,  'h10, 0, 0, 1, 0, 1, 'h1111,  CMD_NONE,  0,     0);
    vecs[3]  = mk(1, 'h12,  'h3333,  'h11, 0, 0, 1, 0, 1, 'h2222,  CMD_NONE,  0,     0);
    vecs[4]  = mk(0, 0,     0,       'h12, 0, 0, 1, 0, 1, 'h3333,  CMD_STORE, 'h10,  'h1111);
    vecs[5]  = mk(0, 0,     0,       'h13, 0, 0, 1, 0, 0, 0,       CMD_STORE, 'h10,  'h1111);
    vecs[6]  = mk(0, 0,     0,       'h10, 0, 1, 1, 0, 1, 'h1111,  CMD_STORE, 'h10,  'h1111);
    vecs[7]  = mk(0, 0,     0,       'h10, 0, 0, 1, 0, 0, 0,       CMD_NONE,  0,     0);
    vecs[8]  = mk(1, 'h13,  'h4444,  'h11, 0, 0, 1, 0, 1, 'h2222,  CMD_NONE,  0,     0);
    vecs[9]  = mk(1, 'h14,  'h5555,  'h13, 0, 0, 1, 0, 1, 'h4444,  CMD_STORE, 'h11,  'h2222);
    vecs[10] = mk(1, 'h15,  'h6666,  'h14, 0, 1, 0, 0, 1, 'h5555,  CMD_STORE, 'h11,  'h2222);
    vecs[11] = mk(0, 0,     0,       'h15, 0, 0, 1, 0, 0, 0,       CMD_STORE, 'h12,  'h3333);
    vecs[12] = mk(0, 0,     0,       'h12, 1, 1, 1, 0, 1, 'h3333,  CMD_STORE, 'h12,  'h3333);
    vecs[13] = mk(0, 0,     0,       'h12, 1, 1, 1, 0, 0, 0,       CMD_STORE, 'h13,  'h4444);
    vecs[14] = mk(0, 0,     0,       'h14, 1, 1, 1, 0, 1, 'h5555,  CMD_STORE, 'h14,  'h5555);
    vecs[15] = mk(0, 0,     0,       'h14, 0, 0, 1, 1, 0, 0,       CMD_NONE,  0,     0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ev, vecs[i].eidx, vecs[i].eblk, vecs[i].lidx, vecs[i].fl, vecs[i].ack);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].x_rdy, vecs[i].x_emp, vecs[i].x_hit,
              vecs[i].x_lblk, vecs[i].x_cmd, vecs[i].x_qidx, vecs[i].x_qblk);
      tick();
    end

    // Duplicate index: lookup must return the youngest data either way.
    drive(1, 'h30, 'hAAAA, 'h30, 0, 0);
    #1 chk("dup0 hit", 64'(lookup_hit), 64'(0));
    tick();
    drive(1, 'h30, 'hBBBB, 'h30, 0, 0);
    #1 chk("dup1 lblk", lookup_blk, 'hAAAA);
    tick();
    drive(0, 0, 0, 'h30, 0, 0);
    #1 chk_all("dup2", 1, 0, 1, 'hBBBB, CMD_NONE, 0, 0);
    tick();
    drive(0, 0, 0, 'h30, 1, 1);
    #1 chk("dup3 cmd", 64'(mem_qry_cmd), 64'(CMD_NONE));
    tick();
`ifdef VICTIM_BUFFER_COALESCE_EN
    #1 chk_all("dup4", 1, 0, 1, 'hBBBB, CMD_STORE, 'h30, 'hBBBB);
    tick();
`else
    #1 chk_all("dup4", 1, 0, 1, 'hBBBB, CMD_STORE, 'h30, 'hAAAA);
    tick();
    #1 chk_all("dup5", 1, 0, 1, 'hBBBB, CMD_STORE, 'h30, 'hBBBB);
    tick();
`endif
    drive(0, 0, 0, 'h30, 0, 0);
    #1 chk_all("dup6", 1, 1, 0, 0, CMD_NONE, 0, 0);
    tick();

    // Flush push-to-store latency of one cycle, then push+pop of the same index.
    drive(1, 'h40, 'hC0C0, 'h40, 1, 0);
    #1 chk_all("lat0", 1, 1, 0, 0, CMD_NONE, 0, 0);
    tick();
    drive(1, 'h40, 'hD0D0, 'h40, 1, 1);
    #1 chk_all("lat1", 1, 0, 1, 'hC0C0, CMD_STORE, 'h40, 'hC0C0);
    tick();
    drive(0, 0, 0, 'h40, 1, 1);
    #1 chk_all("lat2", 1, 0, 1, 'hD0D0, CMD_STORE, 'h40, 'hD0D0);
    tick();
    drive(0, 0, 0, 'h40, 0, 0);
    #1 chk_all("lat3", 1, 1, 0, 0, CMD_NONE, 0, 0);
    tick();

    // Reset during the first store drops everything.
    drive(1, 'h50, 'hE1, 'h51, 0, 0);
    tick();
    drive(1, 'h51, 'hE2, 'h51, 1, 0);
    tick();
    drive(0, 0, 0, 'h51, 1, 0);
    #1 chk_all("rst0", 1, 0, 1, 'hE2, CMD_STORE, 'h50, 'hE1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 'h51, 0, 0);
    #1 chk_all("rst1", 1, 1, 0, 0, CMD_NONE, 0, 0);
    tick();
    #1 chk_all("rst2", 1, 1, 0, 0, CMD_NONE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
